uart_rx_fifo_bus: RTL and testbench



---
 rtl/cpu_reg_package.sv | 61 ++++++
 rtl/sync_fifo_mem.sv | 36 +++
 rtl/uart_rx_fifo_bus.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_fifo_bus.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_reg_package.sv
// cpu_reg_package
//   Shared CPU bus definitions: bus widths, the peripheral address map with
//   start/end lookup helpers, and the register layout of the UART receive
//   FIFO block (register offsets, STATUS and CONTROL bit positions).
//   No ports; imported by the bus peripherals.
package cpu_reg_package;

  localparam int address_width = 32;
  localparam int data_width    = 32;

  // Peripheral regions decoded on the CPU bus.
  typedef enum logic [1:0] {
    ram_e          = 2'd0,
    uart_e         = 2'd1,
    uart_rx_fifo_e = 2'd2,
    unmapped_e     = 2'd3
  } cpu_address_e;

  // First byte address of a region.
  function automatic logic [address_width-1:0] get_address_start(input cpu_address_e region);
    logic [address_width-1:0] addr;
    case (region)
      ram_e:          addr = 32'h0000_0000;
      uart_e:         addr = 32'h0000_9000;
      uart_rx_fifo_e: addr = 32'h0000_9100;
      default:        addr = 32'hFFFF_FFFF;
    endcase
    return addr;
  endfunction

  // Last byte address of a region (inclusive).
  function automatic logic [address_width-1:0] get_address_end(input cpu_address_e region);
    logic [address_width-1:0] addr;
    case (region)
      ram_e:          addr = 32'h0000_8FFF;
      uart_e:         addr = 32'h0000_900F;
      uart_rx_fifo_e: addr = 32'h0000_910B;
      default:        addr = 32'hFFFF_FFFF;
    endcase
    return addr;
  endfunction

  // Receive FIFO register offsets from the block base address.
  localparam logic [address_width-1:0] RxFifoDataOff   = 32'h0000_0000;
  localparam logic [address_width-1:0] RxFifoStatusOff = 32'h0000_0004;
  localparam logic [address_width-1:0] RxFifoCtrlOff   = 32'h0000_0008;

  // DATA register layout.
  localparam int RxDataValidBit = 8;

  // STATUS register layout (count occupies the low bits).
  localparam int RxStatusEmptyBit = 16;
  localparam int RxStatusFullBit  = 17;
  localparam int RxStatusOvfBit   = 18;
  localparam int RxStatusIrqBit   = 19;

  // CONTROL register layout.
  localparam int RxCtrlFlushBit = 0;
  localparam int RxCtrlClrOvfBit = 1;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
//   Depth x Width storage for the receive FIFO. One synchronous write port,
//   one combinational read port addressed by pointer. The array carries no
//   reset: stale entries are never observable because occupancy is tracked
//   by the owner.
// Ports:
//   clk_i    - clock
//   wr_en_i  - write strobe
//   waddr_i  - write pointer
//   wdata_i  - write data
//   raddr_i  - read pointer
//   rdata_o  - entry at raddr_i (combinational)
module sync_fifo_mem #(
  parameter int Depth = 16,
  parameter int Width = 8
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_r [Depth];

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/uart_rx_fifo_bus.sv
// uart_rx_fifo_bus
//   Decoupling FIFO between the UART receiver and the CPU bus. Received bytes
//   are queued; the CPU sees three registers at BaseAddress:
//     +0 DATA    (read pops: {valid, byte}, 0 when empty)
//     +4 STATUS  (count, empty, full, sticky overflow, irq)
//     +8 CONTROL (write-only: bit0 flush, bit1 clear overflow)
//   Each bus access acts once even if the CPU holds the address: an access is
//   new only when the address or the write enable changed since last cycle.
// Optional feature macro: UART_RX_FIFO_IRQ_EN adds irq_o, a registered level
//   interrupt = (count >= IrqThreshold) | overflow, mirrored in STATUS bit 19.
// Ports:
//   clk_i, reset_n_i      - clock, asynchronous active-low reset
//   rx_data_i, rx_valid_i - byte and one-cycle strobe from the receiver
//   address_i, we_i, wdata_i - CPU bus request
//   rdata_o               - registered read data, 0 when not addressed
//   irq_o                 - level interrupt (UART_RX_FIFO_IRQ_EN only)
module uart_rx_fifo_bus
  import cpu_reg_package::*;
#(
  parameter logic [address_width-1:0] BaseAddress  = 32'h0000_9100,
  parameter int                       Depth        = 16,
  parameter int                       IrqThreshold = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  input  logic [address_width-1:0] address_i,
  input  logic                     we_i,
  input  logic [data_width-1:0]    wdata_i,
  output logic [data_width-1:0]    rdata_o
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic                     irq_o
`endif
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PtrOne   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CntOne   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DepthCnt = CW'(Depth);

  localparam logic [address_width-1:0] DataAddr   = BaseAddress + RxFifoDataOff;
  localparam logic [address_width-1:0] StatusAddr = BaseAddress + RxFifoStatusOff;
  localparam logic [address_width-1:0] CtrlAddr   = BaseAddress + RxFifoCtrlOff;

  // Legal configuration: power-of-two depth of at least 4, threshold in range.
  localparam logic CfgOk = (Depth >= 4) && ((Depth & (Depth - 1)) == 0) &&
                           (IrqThreshold >= 1) && (IrqThreshold <= Depth);

  logic [address_width-1:0] addr_q_r;
  logic                     we_q_r;
  logic [AW-1:0]            wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]            count_r;
  logic                     ovf_r;
  logic [data_width-1:0]    rdata_r;
  logic                     irq_s;

  logic [AW-1:0]         wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]         count_nxt_s;
  logic                  ovf_nxt_s;
  logic [data_width-1:0] rdata_nxt_s;
  logic [data_width-1:0] status_s;
  logic [7:0]            head_s;

  logic new_access_s, sel_data_s, sel_status_s, sel_ctrl_s;
  logic empty_s, full_s, pop_s, ctrl_wr_s, flush_s, clr_s, push_s, ovf_set_s;

  // CONTROL ignores the upper write-data bits; collected here on purpose.
  logic unused_s;
  assign unused_s = ^{wdata_i[data_width-1:2], CfgOk};

  assign new_access_s = (address_i != addr_q_r) || (we_i != we_q_r);
  assign sel_data_s   = (address_i == DataAddr);
  assign sel_status_s = (address_i == StatusAddr);
  assign sel_ctrl_s   = (address_i == CtrlAddr);

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == DepthCnt);

  assign pop_s     = new_access_s && !we_i && sel_data_s && !empty_s;
  assign ctrl_wr_s = new_access_s && we_i && sel_ctrl_s;
  assign flush_s   = ctrl_wr_s && wdata_i[RxCtrlFlushBit];
  assign clr_s     = ctrl_wr_s && wdata_i[RxCtrlClrOvfBit];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_s    = rx_valid_i && (!full_s || pop_s) && !flush_s;
  assign ovf_set_s = rx_valid_i && full_s && !pop_s && !flush_s;

  sync_fifo_mem #(
    .Depth (Depth),
    .Width (8)
  ) u_mem (
    .clk_i   (clk_i),
    .wr_en_i (push_s),
    .waddr_i (wr_ptr_r),
    .wdata_i (rx_data_i),
    .raddr_i (rd_ptr_r),
    .rdata_o (head_s)
  );

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [CW-1:0] IrqThr = CW'(IrqThreshold);
  logic irq_r;

  // Registered interrupt level from current occupancy and overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (count_r >= IrqThr) || ovf_r;
    end
  end

  assign irq_s = irq_r;
  assign irq_o = irq_r;
`else
  assign irq_s = 1'b0;
`endif

  // STATUS word assembled from live FIFO state.
  always_comb begin
    status_s                   = {data_width{1'b0}};
    status_s[CW-1:0]           = count_r;
    status_s[RxStatusEmptyBit] = empty_s;
    status_s[RxStatusFullBit]  = full_s;
    status_s[RxStatusOvfBit]   = ovf_r;
    status_s[RxStatusIrqBit]   = irq_s;
  end

  // Next-state decode for pointers, count, overflow and read data.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    ovf_nxt_s    = ovf_r;
    rdata_nxt_s  = {data_width{1'b0}};

    if (flush_s) begin
      wr_ptr_nxt_s = {AW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PtrOne;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PtrOne;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CntOne;
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CntOne;
      end else begin
        count_nxt_s = count_r;
      end
    end

    // Setting overflow takes priority over clearing it.
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_s) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    // A held DATA address keeps the byte it popped instead of popping again.
    if (we_i) begin
      rdata_nxt_s = {data_width{1'b0}};
    end else if (sel_data_s) begin
      if (!new_access_s) begin
        rdata_nxt_s = rdata_r;
      end else if (pop_s) begin
        rdata_nxt_s = {{(data_width-RxDataValidBit-1){1'b0}}, 1'b1, head_s};
      end else begin
        rdata_nxt_s = {data_width{1'b0}};
      end
    end else if (sel_status_s) begin
      rdata_nxt_s = status_s;
    end else begin
      rdata_nxt_s = {data_width{1'b0}};
    end
  end

  // Bus-side state: access tracking, FIFO bookkeeping and read data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q_r <= {address_width{1'b0}};
      we_q_r   <= 1'b0;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      rdata_r  <= {data_width{1'b0}};
    end else begin
      addr_q_r <= address_i;
      we_q_r   <= we_i;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ovf_r    <= ovf_nxt_s;
      rdata_r  <= rdata_nxt_s;
    end
  end

  assign rdata_o = rdata_r;

endmodule

// File: tb/tb_uart_rx_fifo_bus.sv
// tb_uart_rx_fifo_bus
//   Randomized and directed stimulus for uart_rx_fifo_bus. A queue-based
//   reference model predicts every cycle's read data; expectations go into a
//   scoreboard queue that a separate monitor drains on the falling edge.
//   Define UART_RX_FIFO_IRQ_EN to also check irq_o and STATUS bit 19.
module tb_uart_rx_fifo_bus;

  localparam int          Depth = 16;
  localparam int          Thr   = 8;
  localparam logic [31:0] Base  = 32'h0000_9100;
  localparam logic [31:0] Idle  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] address = 32'h0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
`ifdef UART_RX_FIFO_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo_bus dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .address_i  (address),
    .we_i       (we),
    .wdata_i    (wdata),
    .rdata_o    (rdata)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  int checks = 0;
  int passed = 0;

  function automatic void check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t exp_q[$];
  logic rd_issue = 1'b0;
  logic rd_due = 1'b0;

  always @(posedge clk) rd_due <= rd_issue;

  always @(negedge clk) begin
    if (rd_due) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL orphan_read: got %h, expected nothing queued", rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, rdata, e.val);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          movf = 1'b0;
  bit          prev_f = 1'b0;
  logic [31:0] last_exp = 32'h0;

  function automatic bit irq_level();
    return (mq.size() >= Thr) || movf;
  endfunction

  function automatic logic [31:0] status_word();
    logic [31:0] s;
    s = 32'h0;
    s[4:0] = 5'(mq.size());
    s[16]  = (mq.size() == 0);
    s[17]  = (mq.size() == Depth);
    s[18]  = movf;
`ifdef UART_RX_FIFO_IRQ_EN
    s[19]  = prev_f;
`endif
    return s;
  endfunction

  // kind: 0 idle address, 1 DATA read, 2 STATUS read, 3 CONTROL write,
  //       4 DATA address held from the previous cycle.
  task automatic transact(input int kind, input bit push, input logic [7:0] b, input logic [1:0] ctl);
    logic [31:0] e;
    exp_t        x;
    bit          cur_f, flush, clr, set;
    cur_f = irq_level();
    e = 32'h0;
    x.tag = "idle_read";
    address = Idle;
    we = 1'b0;
    wdata = 32'h0;
    case (kind)
      1: begin
        address = Base;
        x.tag = "data_read";
        if (mq.size() > 0) e = {23'h0, 1'b1, mq.pop_front()};
      end
      2: begin
        address = Base + 32'h4;
        x.tag = "status_read";
        e = status_word();
      end
      3: begin
        address = Base + 32'h8;
        we = 1'b1;
        wdata = {30'h0, ctl};
        x.tag = "ctrl_read";
      end
      4: begin
        address = Base;
        x.tag = "data_hold";
        e = last_exp;
      end
      default: ;
    endcase
    flush = (kind == 3) && ctl[0];
    clr   = (kind == 3) && ctl[1];
    set   = 1'b0;
    if (flush) mq.delete();
    else if (push) begin
      if (mq.size() < Depth) mq.push_back(b);
      else set = 1'b1;
    end
    if (set) movf = 1'b1;
    else if (clr) movf = 1'b0;
    rx_valid = push;
    rx_data  = b;
    rd_issue = 1'b1;
    x.val = e;
    exp_q.push_back(x);
    last_exp = e;
    prev_f = cur_f;
    @(posedge clk);
    #1;
`ifdef UART_RX_FIFO_IRQ_EN
    check("irq", {31'h0, irq}, {31'h0, cur_f});
`endif
  endtask

  task automatic push_byte(input logic [7:0] b);
    transact(0, 1'b1, b, 2'b00);
  endtask

  task automatic read_data();
    transact(1, 1'b0, 8'h00, 2'b00);
    transact(0, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic read_status();
    transact(2, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic write_ctrl(input logic [1:0] v, input bit push, input logic [7:0] b);
    transact(3, push, b, v);
    transact(0, 1'b0, 8'h00, 2'b00);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    rd_issue = 1'b0;
    rx_valid = 1'b0;
    address  = Idle;
    we       = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("async_reset_rdata", rdata, 32'h0);
`ifdef UART_RX_FIFO_IRQ_EN
    check("async_reset_irq", {31'h0, irq}, 32'h0);
`endif
    mq.delete();
    movf = 1'b0;
    prev_f = 1'b0;
    last_exp = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    bit p;
    logic [7:0] b;

    #2;
    check("reset_rdata", rdata, 32'h0);
    #20;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    read_status();
    read_data();

    // Basic ordering.
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    repeat (3) read_data();
    read_status();

    // Overflow: 17 pushes into 16 entries, drain, clear.
    for (int i = 0; i < 17; i++) push_byte(8'h50 + 8'(i));
    read_status();
    for (int i = 0; i < 16; i++) read_data();
    read_data();
    write_ctrl(2'b10, 1'b0, 8'h00);
    read_status();

    // Push and pop together while full: no overflow, new byte last.
    for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
    transact(1, 1'b1, 8'hAA, 2'b00);
    transact(0, 1'b0, 8'h00, 2'b00);
    read_status();
    for (int i = 0; i < 16; i++) read_data();

    // Held DATA address pops once.
    push_byte(8'h11);
    push_byte(8'h22);
    transact(1, 1'b0, 8'h00, 2'b00);
    transact(4, 1'b0, 8'h00, 2'b00);
    transact(4, 1'b0, 8'h00, 2'b00);
    transact(0, 1'b0, 8'h00, 2'b00);
    read_status();
    read_data();

    // Overflow set and clear in the same cycle: set wins.
    for (int i = 0; i < 16; i++) push_byte(8'h70 + 8'(i));
    write_ctrl(2'b10, 1'b1, 8'hEE);
    read_status();
    // Flush coincident with a push: FIFO empty, overflow kept.
    write_ctrl(2'b01, 1'b1, 8'hBB);
    read_status();
    read_data();
    // Flush and clear in one write.
    for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i));
    write_ctrl(2'b11, 1'b0, 8'h00);
    read_status();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      p = ($urandom_range(0, 99) < 55);
      b = 8'($urandom);
      if (r < 35) begin
        transact(0, p, b, 2'b00);
      end else if (r < 68) begin
        transact(1, p, b, 2'b00);
        if ($urandom_range(0, 3) == 0) transact(4, 1'b0, 8'h00, 2'b00);
        transact(0, 1'b0, 8'h00, 2'b00);
      end else if (r < 92) begin
        transact(2, p, b, 2'b00);
      end else begin
        write_ctrl(2'($urandom_range(0, 3)), p, b);
      end
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) push_byte(8'h90 + 8'(i));
    read_status();
    mid_reset();
    read_status();
    read_data();

    rd_issue = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
